// File: rtl/sha256_nonce_sched.sv
// sha256_nonce_sched: walks a nonce range through one sha256_engine instance.
// Each nonce gets an engine reset, a start, one 16-word block served from a
// local template (nonce substituted at nonce_idx_i), and a wait for the hash.
// The hash is compared against target_i. The job stops on the first hit, at the
// end of the range, on timeout, or on abort_i.
module sha256_nonce_sched #(
    parameter int unsigned RST_CYC     = 2,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         tpl_we_i,
    input  logic [3:0]   tpl_addr_i,
    input  logic [31:0]  tpl_dat_i,
    input  logic [3:0]   nonce_idx_i,
    input  logic [31:0]  nonce_first_i,
    input  logic [31:0]  nonce_last_i,
    input  logic [255:0] target_i,
    input  logic         dbl_hash_i,
    input  logic         run_i,
    input  logic         abort_i,
    output logic         busy_o,
    output logic         done_o,
    output logic         hit_o,
    output logic         timeout_o,
    output logic [31:0]  hit_nonce_o,
    output logic [255:0] hit_hash_o,
    output logic [31:0]  nonce_cnt_o,
    output logic         eng_rstn_o,
    output logic         eng_start_o,
    output logic         eng_dbl_hash_o,
    input  logic         eng_ready_i,
    input  logic         eng_rd_en_i,
    output logic         eng_rd_vld_o,
    output logic [31:0]  eng_rd_dat_o,
    output logic         eng_empty_o,
    output logic         eng_dma_o,
    input  logic         eng_valid_i,
    input  logic [255:0] eng_hash_i
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ERST,
        S_WRDY,
        S_FEED,
        S_WVLD,
        S_CHECK,
        S_DONE
    } state_t;

    state_t        state;
    logic [31:0]   tpl [16];
    logic [31:0]   nonce;
    logic [4:0]    ptr;
    logic [31:0]   rst_cnt;
    logic [31:0]   to_cnt;
    logic [255:0]  hash_q;
    logic          run_q;
    logic          run_rise;

    assign run_rise    = run_i & ~run_q;
    assign eng_dma_o   = 1'b0;
    // Block exhausted once the word pointer has reached 16.
    assign eng_empty_o = ptr[4];

    // Template storage: writable only while no job is running.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < 16; i++) begin
                tpl[i] <= '0;
            end
        end else if (tpl_we_i && !busy_o) begin
            tpl[tpl_addr_i] <= tpl_dat_i;
        end
    end

    // Job sequencer: engine reset, start, block feed, hash wait and target compare.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state          <= S_IDLE;
            nonce          <= '0;
            ptr            <= '0;
            rst_cnt        <= '0;
            to_cnt         <= '0;
            hash_q         <= '0;
            run_q          <= 1'b0;
            busy_o         <= 1'b0;
            done_o         <= 1'b0;
            hit_o          <= 1'b0;
            timeout_o      <= 1'b0;
            hit_nonce_o    <= '0;
            hit_hash_o     <= '0;
            nonce_cnt_o    <= '0;
            eng_rstn_o     <= 1'b0;
            eng_start_o    <= 1'b0;
            eng_dbl_hash_o <= 1'b0;
            eng_rd_vld_o   <= 1'b0;
            eng_rd_dat_o   <= '0;
        end else begin
            run_q          <= run_i;
            eng_dbl_hash_o <= dbl_hash_i;
            eng_rd_vld_o   <= 1'b0;

            if (abort_i && state != S_IDLE && state != S_DONE) begin
                state       <= S_DONE;
                busy_o      <= 1'b0;
                done_o      <= 1'b1;
                hit_o       <= 1'b0;
                timeout_o   <= 1'b0;
                eng_rstn_o  <= 1'b0;
                eng_start_o <= 1'b0;
            end else begin
                case (state)
                    // DONE differs from IDLE only by the sticky done flag, so a
                    // run edge in either state launches the next job directly.
                    S_IDLE, S_DONE: begin
                        eng_rstn_o  <= 1'b0;
                        eng_start_o <= 1'b0;
                        if (run_rise) begin
                            nonce       <= nonce_first_i;
                            nonce_cnt_o <= '0;
                            done_o      <= 1'b0;
                            hit_o       <= 1'b0;
                            timeout_o   <= 1'b0;
                            busy_o      <= 1'b1;
                            rst_cnt     <= '0;
                            ptr         <= '0;
                            state       <= S_ERST;
                        end
                    end

                    S_ERST: begin
                        if (rst_cnt == RST_CYC - 1) begin
                            eng_rstn_o <= 1'b1;
                            state      <= S_WRDY;
                        end else begin
                            rst_cnt <= rst_cnt + 1;
                        end
                    end

                    S_WRDY: begin
                        if (eng_ready_i) begin
                            eng_start_o <= 1'b1;
                            ptr         <= '0;
                            to_cnt      <= 32'd1;
                            state       <= S_FEED;
                        end
                    end

                    S_FEED: begin
                        to_cnt <= to_cnt + 1;
                        if (to_cnt >= TIMEOUT_CYC) begin
                            timeout_o   <= 1'b1;
                            busy_o      <= 1'b0;
                            done_o      <= 1'b1;
                            eng_rstn_o  <= 1'b0;
                            eng_start_o <= 1'b0;
                            state       <= S_DONE;
                        end else if (ptr[4]) begin
                            eng_start_o <= 1'b0;
                            state       <= S_WVLD;
                        end else if (eng_rd_en_i) begin
                            eng_rd_vld_o <= 1'b1;
                            eng_rd_dat_o <= (ptr[3:0] == nonce_idx_i) ? nonce : tpl[ptr[3:0]];
                            ptr          <= ptr + 5'd1;
                        end
                    end

                    S_WVLD: begin
                        to_cnt <= to_cnt + 1;
                        if (eng_valid_i) begin
                            hash_q <= eng_hash_i;
                            state  <= S_CHECK;
                        end else if (to_cnt >= TIMEOUT_CYC) begin
                            timeout_o  <= 1'b1;
                            busy_o     <= 1'b0;
                            done_o     <= 1'b1;
                            eng_rstn_o <= 1'b0;
                            state      <= S_DONE;
                        end
                    end

                    S_CHECK: begin
                        nonce_cnt_o <= nonce_cnt_o + 1;
                        hit_nonce_o <= nonce;
                        hit_hash_o  <= hash_q;
                        if (hash_q <= target_i) begin
                            hit_o      <= 1'b1;
                            busy_o     <= 1'b0;
                            done_o     <= 1'b1;
                            eng_rstn_o <= 1'b0;
                            state      <= S_DONE;
                        end else if (nonce == nonce_last_i) begin
                            busy_o     <= 1'b0;
                            done_o     <= 1'b1;
                            eng_rstn_o <= 1'b0;
                            state      <= S_DONE;
                        end else begin
                            nonce      <= nonce + 1;
                            rst_cnt    <= '0;
                            eng_rstn_o <= 1'b0;
                            state      <= S_ERST;
                        end
                    end

                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sha256_nonce_sched.sv
// Testbench for sha256_nonce_sched: a behavioural engine stub serves the block
// protocol, and a scoreboard checks each job's final status on done_o rise.
module tb_sha256_nonce_sched;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         tpl_we_i;
    logic [3:0]   tpl_addr_i;
    logic [31:0]  tpl_dat_i;
    logic [3:0]   nonce_idx_i;
    logic [31:0]  nonce_first_i;
    logic [31:0]  nonce_last_i;
    logic [255:0] target_i;
    logic         dbl_hash_i;
    logic         run_i;
    logic         abort_i;
    logic         busy_o;
    logic         done_o;
    logic         hit_o;
    logic         timeout_o;
    logic [31:0]  hit_nonce_o;
    logic [255:0] hit_hash_o;
    logic [31:0]  nonce_cnt_o;
    logic         eng_rstn_o;
    logic         eng_start_o;
    logic         eng_dbl_hash_o;
    logic         eng_ready_i;
    logic         eng_rd_en_i;
    logic         eng_rd_vld_o;
    logic [31:0]  eng_rd_dat_o;
    logic         eng_empty_o;
    logic         eng_dma_o;
    logic         eng_valid_i;
    logic [255:0] eng_hash_i;

    localparam logic [255:0] ABC_HASH =
        256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;

    sha256_nonce_sched #(
        .RST_CYC     (2),
        .TIMEOUT_CYC (64)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .tpl_we_i       (tpl_we_i),
        .tpl_addr_i     (tpl_addr_i),
        .tpl_dat_i      (tpl_dat_i),
        .nonce_idx_i    (nonce_idx_i),
        .nonce_first_i  (nonce_first_i),
        .nonce_last_i   (nonce_last_i),
        .target_i       (target_i),
        .dbl_hash_i     (dbl_hash_i),
        .run_i          (run_i),
        .abort_i        (abort_i),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .hit_o          (hit_o),
        .timeout_o      (timeout_o),
        .hit_nonce_o    (hit_nonce_o),
        .hit_hash_o     (hit_hash_o),
        .nonce_cnt_o    (nonce_cnt_o),
        .eng_rstn_o     (eng_rstn_o),
        .eng_start_o    (eng_start_o),
        .eng_dbl_hash_o (eng_dbl_hash_o),
        .eng_ready_i    (eng_ready_i),
        .eng_rd_en_i    (eng_rd_en_i),
        .eng_rd_vld_o   (eng_rd_vld_o),
        .eng_rd_dat_o   (eng_rd_dat_o),
        .eng_empty_o    (eng_empty_o),
        .eng_dma_o      (eng_dma_o),
        .eng_valid_i    (eng_valid_i),
        .eng_hash_i     (eng_hash_i)
    );

    always #5 clk_i = ~clk_i;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    always @(posedge clk_i) cyc <= cyc + 1;

    typedef struct {
        string        name;
        logic         hit;
        logic         tmo;
        logic [31:0]  cnt;
        logic [31:0]  nonce;
        logic [255:0] hash;
        bit           full;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] nonce_q[$];
    logic [31:0] tpl_exp [16];
    logic [31:0] rx [16];
    int          mode;       // 0: abc hash, 1: hash derived from nonce word, 2: never valid
    int          nbeat;
    int          st;
    int          lat;
    int          extra;
    int          vld_total = 0;
    int          t_start = 0;
    int          t_tmo = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", name, act, req);
        end
    endtask

    task automatic push_exp(input string name, input logic hit, input logic tmo,
                            input logic [31:0] cnt, input logic [31:0] nonce,
                            input logic [255:0] hash, input bit full);
        exp_t e;
        e.name = name; e.hit = hit; e.tmo = tmo; e.cnt = cnt;
        e.nonce = nonce; e.hash = hash; e.full = full;
        exp_q.push_back(e);
    endtask

    task automatic check_block();
        logic [31:0] n;
        logic [31:0] w;
        int          bad;
        bad = -1;
        n_chk++;
        if (nonce_q.size() == 0) begin
            n_fail++;
            $display("FAIL feed_block: got unexpected block, want none");
        end else begin
            n = nonce_q.pop_front();
            for (int i = 0; i < 16; i++) begin
                w = (i == 3) ? n : tpl_exp[i];
                if (rx[i] !== w && bad < 0) bad = i;
            end
            if (bad >= 0) begin
                n_fail++;
                $display("FAIL feed_block word %0d: got %0h, want %0h (nonce %0h)",
                         bad, rx[bad], (bad == 3) ? n : tpl_exp[bad], n);
            end
        end
    endtask

    // Engine stub: ready after reset release, reads 16 words, answers after a short latency.
    initial begin
        eng_ready_i = 1'b0; eng_rd_en_i = 1'b0; eng_valid_i = 1'b0; eng_hash_i = '0;
        st = 0; nbeat = 0; lat = 0; extra = 0;
        forever begin
            @(negedge clk_i);
            if (eng_rd_vld_o) vld_total++;
            if (!eng_rstn_o) begin
                st = 0; nbeat = 0; extra = 0;
                eng_ready_i = 1'b0; eng_rd_en_i = 1'b0; eng_valid_i = 1'b0;
            end else begin
                case (st)
                    0: begin
                        if (eng_start_o) begin
                            eng_ready_i = 1'b0; eng_rd_en_i = 1'b1; st = 1;
                        end else begin
                            eng_ready_i = 1'b1;
                        end
                    end
                    1: begin
                        if (eng_rd_vld_o && nbeat < 16) begin
                            rx[nbeat] = eng_rd_dat_o; nbeat++;
                        end
                        if (nbeat == 16) begin
                            eng_rd_en_i = 1'b0; st = 2; lat = 3;
                            check_block();
                        end
                    end
                    2: begin
                        if (eng_rd_vld_o) extra++;
                        if (lat > 0) lat--;
                        else if (mode != 2) begin
                            check("no_extra_beats", 256'(extra), 256'd0);
                            eng_valid_i = 1'b1;
                            eng_hash_i  = (mode == 0) ? ABC_HASH : {rx[3] ^ 32'hC, 224'h0};
                            st = 3;
                        end
                    end
                    default: begin
                        eng_valid_i = 1'b0;
                    end
                endcase
            end
        end
    end

    // Scoreboard monitor: compares final job status against the queued expectation.
    logic done_q = 1'b0, start_q = 1'b0, tmo_q = 1'b0;
    exp_t mon_e;
    initial begin
        forever begin
            @(negedge clk_i);
            if (eng_start_o && !start_q) t_start = cyc;
            if (timeout_o && !tmo_q) t_tmo = cyc;
            if (done_o && !done_q) begin
                if (exp_q.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL unexpected_done: got done_o=1, want no job end");
                end else begin
                    mon_e = exp_q.pop_front();
                    check({mon_e.name, "_hit"},     256'(hit_o),       256'(mon_e.hit));
                    check({mon_e.name, "_timeout"}, 256'(timeout_o),   256'(mon_e.tmo));
                    check({mon_e.name, "_cnt"},     256'(nonce_cnt_o), 256'(mon_e.cnt));
                    check({mon_e.name, "_busy"},    256'(busy_o),      256'd0);
                    if (mon_e.full) begin
                        check({mon_e.name, "_nonce"}, 256'(hit_nonce_o), 256'(mon_e.nonce));
                        check({mon_e.name, "_hash"},  hit_hash_o,        mon_e.hash);
                    end
                end
            end
            done_q = done_o; start_q = eng_start_o; tmo_q = timeout_o;
        end
    end

    task automatic run_job(input logic [31:0] first, input logic [31:0] last,
                           input logic [255:0] tgt, input int m);
        @(negedge clk_i);
        nonce_first_i = first; nonce_last_i = last; target_i = tgt; mode = m;
        run_i = 1'b1;
        @(negedge clk_i);
        run_i = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int i;
        i = 0;
        while (!done_o && i < 3000) begin
            @(negedge clk_i);
            i++;
        end
        check({name, "_done_reached"}, 256'(done_o), 256'd1);
        @(negedge clk_i);
    endtask

    initial begin
        rst_i = 1'b1; tpl_we_i = 1'b0; tpl_addr_i = '0; tpl_dat_i = '0;
        nonce_idx_i = 4'd3; nonce_first_i = '0; nonce_last_i = '0; target_i = '0;
        dbl_hash_i = 1'b0; run_i = 1'b0; abort_i = 1'b0; mode = 0;
        for (int i = 0; i < 16; i++) tpl_exp[i] = 32'h0;
        tpl_exp[0]  = 32'h61626380;
        tpl_exp[15] = 32'h00000018;

        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
        check("rst_busy",    256'(busy_o),       256'd0);
        check("rst_done",    256'(done_o),       256'd0);
        check("rst_hit",     256'(hit_o),        256'd0);
        check("rst_rstn",    256'(eng_rstn_o),   256'd0);
        check("rst_start",   256'(eng_start_o),  256'd0);
        check("rst_vld",     256'(eng_rd_vld_o), 256'd0);
        check("rst_empty",   256'(eng_empty_o),  256'd0);
        check("rst_cnt",     256'(nonce_cnt_o),  256'd0);
        check("rst_hhash",   hit_hash_o,         256'd0);

        for (int i = 0; i < 16; i++) begin
            @(negedge clk_i);
            tpl_we_i = 1'b1; tpl_addr_i = 4'(i); tpl_dat_i = tpl_exp[i];
        end
        @(negedge clk_i);
        tpl_we_i = 1'b0;

        // abc block, all-ones target: hit on the only nonce
        nonce_q.push_back(32'h0);
        push_exp("abc_hit", 1'b1, 1'b0, 32'd1, 32'h0, ABC_HASH, 1'b1);
        run_job(32'h0, 32'h0, '1, 0);
        check("busy_in_job", 256'(busy_o), 256'd1);
        wait_done("abc_hit");

        // same block, zero target: no hit, last nonce/hash latched; dbl_hash forwarded
        dbl_hash_i = 1'b1;
        nonce_q.push_back(32'h0);
        push_exp("abc_miss", 1'b0, 1'b0, 32'd1, 32'h0, ABC_HASH, 1'b1);
        run_job(32'h0, 32'h0, '0, 0);
        @(negedge clk_i);
        check("dbl_fwd", 256'(eng_dbl_hash_o), 256'd1);
        wait_done("abc_miss");
        dbl_hash_i = 1'b0;

        // range 5..9, hash MSW = nonce^C; target MSW 4 hits only nonce 8
        for (int n = 5; n <= 8; n++) nonce_q.push_back(32'(n));
        push_exp("range_hit", 1'b1, 1'b0, 32'd4, 32'd8, {32'h4, 224'h0}, 1'b1);
        run_job(32'd5, 32'd9, {32'h4, {224{1'b1}}}, 1);
        @(negedge clk_i);
        tpl_we_i = 1'b1; tpl_addr_i = 4'd0; tpl_dat_i = 32'hDEADBEEF;   // must be ignored
        @(negedge clk_i);
        tpl_we_i = 1'b0;
        wait_done("range_hit");

        // wrapping range FFFFFFFE..1 with no hit
        nonce_q.push_back(32'hFFFFFFFE);
        nonce_q.push_back(32'hFFFFFFFF);
        nonce_q.push_back(32'h0);
        nonce_q.push_back(32'h1);
        push_exp("wrap_miss", 1'b0, 1'b0, 32'd4, 32'h1, {32'hD, 224'h0}, 1'b1);
        run_job(32'hFFFFFFFE, 32'h1, '0, 1);
        wait_done("wrap_miss");

        // engine never answers: timeout 64 cycles after start rise
        nonce_q.push_back(32'h0);
        push_exp("timeout", 1'b0, 1'b1, 32'd0, 32'h0, '0, 1'b0);
        run_job(32'h0, 32'h0, '1, 2);
        wait_done("timeout");
        check("timeout_latency", 256'(t_tmo - t_start), 256'd64);
        check("timeout_rstn",    256'(eng_rstn_o),      256'd0);

        // abort in the middle of the block feed
        push_exp("abort", 1'b0, 1'b0, 32'd0, 32'h0, '0, 1'b0);
        run_job(32'h0, 32'h0, '1, 0);
        begin
            int i;
            i = 0;
            while (nbeat < 7 && i < 200) begin
                @(posedge clk_i);
                i++;
            end
        end
        check("abort_reached_feed", 256'(nbeat >= 7), 256'd1);
        @(negedge clk_i);
        abort_i = 1'b1;
        @(negedge clk_i);
        abort_i = 1'b0;
        check("abort_done", 256'(done_o),     256'd1);
        check("abort_busy", 256'(busy_o),     256'd0);
        check("abort_rstn", 256'(eng_rstn_o), 256'd0);
        begin
            int vc;
            vc = vld_total;
            repeat (20) @(negedge clk_i);
            check("abort_no_vld", 256'(vld_total - vc), 256'd0);
        end

        // rerun after abort
        nonce_q.push_back(32'h0);
        push_exp("rerun_hit", 1'b1, 1'b0, 32'd1, 32'h0, ABC_HASH, 1'b1);
        run_job(32'h0, 32'h0, '1, 0);
        wait_done("rerun_hit");

        for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk_i);
        check("scoreboard_drained", 256'(exp_q.size()), 256'd0);
        check("nonces_consumed",    256'(nonce_q.size()), 256'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
